// File: rtl/rv_multicycle_control.sv
// rv_multicycle_control: main control FSM for the multicycle RV32I datapath.
// One state per clock. Outputs are Moore, except the BEQ PC enable, which follows Zero in the same cycle.
module rv_multicycle_control #(
    parameter int STATE_WIDTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [6:0]             Opcode,
    input  logic [2:0]             Funct3,
    input  logic                   Funct7b5,
    input  logic                   Funct7b0,
    input  logic                   Zero,
    output logic                   PCWrite,
    output logic                   AdrSrc,
    output logic                   MemWrite,
    output logic                   IRWrite,
    output logic [1:0]             ResultSrc,
    output logic [1:0]             ALUSrcA,
    output logic [1:0]             ALUSrcB,
    output logic [1:0]             ImmSrc,
    output logic                   RegWrite,
    output logic [2:0]             ALUControl,
    output logic                   Illegal,
    output logic                   Retire,
    output logic [STATE_WIDTH-1:0] StateDbg
);

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;

    localparam logic [STATE_WIDTH-1:0] S_FETCH    = STATE_WIDTH'(0);
    localparam logic [STATE_WIDTH-1:0] S_DECODE   = STATE_WIDTH'(1);
    localparam logic [STATE_WIDTH-1:0] S_MEMADR   = STATE_WIDTH'(2);
    localparam logic [STATE_WIDTH-1:0] S_MEMREAD  = STATE_WIDTH'(3);
    localparam logic [STATE_WIDTH-1:0] S_MEMWB    = STATE_WIDTH'(4);
    localparam logic [STATE_WIDTH-1:0] S_MEMWRITE = STATE_WIDTH'(5);
    localparam logic [STATE_WIDTH-1:0] S_EXECR    = STATE_WIDTH'(6);
    localparam logic [STATE_WIDTH-1:0] S_EXECI    = STATE_WIDTH'(7);
    localparam logic [STATE_WIDTH-1:0] S_ALUWB    = STATE_WIDTH'(8);
    localparam logic [STATE_WIDTH-1:0] S_BEQ      = STATE_WIDTH'(9);
    localparam logic [STATE_WIDTH-1:0] S_JAL      = STATE_WIDTH'(10);

    logic [STATE_WIDTH-1:0] state_r;
    logic [STATE_WIDTH-1:0] next_state_s;
    logic                   run_r;
    logic                   illegal_s;
    logic                   pcwrite_s;
    logic                   memwrite_s;
    logic                   irwrite_s;
    logic                   regwrite_s;
    logic                   retire_s;

    // Funct3 -> ALU op. sub/mul exist only for R-type; I-type funct3 000 is always add.
    function automatic logic [2:0] alu_decode(input logic       is_rtype,
                                              input logic [2:0] funct3,
                                              input logic       f7b5,
                                              input logic       f7b0);
        logic [2:0] ctl;
        case (funct3)
            3'b000: begin
                if (is_rtype && f7b0) begin
                    ctl = 3'b010;
                end else if (is_rtype && f7b5) begin
                    ctl = 3'b001;
                end else begin
                    ctl = 3'b000;
                end
            end
            3'b001:  ctl = 3'b110;
            3'b010:  ctl = 3'b111;
            3'b100:  ctl = 3'b101;
            3'b110:  ctl = 3'b100;
            3'b111:  ctl = 3'b011;
            default: ctl = 3'b000;
        endcase
        return ctl;
    endfunction

    // Flag encodings outside the supported subset. Only used while in DECODE.
    always_comb begin
        illegal_s = 1'b0;
        case (Opcode)
            OP_LOAD:  illegal_s = (Funct3 != 3'b010);
            OP_STORE: illegal_s = (Funct3 != 3'b010);
            OP_RTYPE: illegal_s = (Funct3 == 3'b011) || (Funct3 == 3'b101) || (Funct7b5 && Funct7b0);
            OP_ITYPE: illegal_s = (Funct3 == 3'b011) || (Funct3 == 3'b101);
            OP_BEQ:   illegal_s = (Funct3 != 3'b000);
            OP_JAL:   illegal_s = 1'b0;
            default:  illegal_s = 1'b1;
        endcase
    end

    // State register and run flag. Reset aborts an in-flight instruction immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= S_FETCH;
            run_r   <= 1'b0;
        end else begin
            state_r <= next_state_s;
            run_r   <= 1'b1;
        end
    end

    // Next-state logic. FETCH is held until the run flag is set.
    always_comb begin
        next_state_s = S_FETCH;
        if (!run_r) begin
            next_state_s = S_FETCH;
        end else begin
            case (state_r)
                S_FETCH:  next_state_s = S_DECODE;
                S_DECODE: begin
                    if (illegal_s) begin
                        next_state_s = S_FETCH;
                    end else begin
                        case (Opcode)
                            OP_LOAD, OP_STORE: next_state_s = S_MEMADR;
                            OP_RTYPE:          next_state_s = S_EXECR;
                            OP_ITYPE:          next_state_s = S_EXECI;
                            OP_BEQ:            next_state_s = S_BEQ;
                            OP_JAL:            next_state_s = S_JAL;
                            default:           next_state_s = S_FETCH;
                        endcase
                    end
                end
                S_MEMADR: begin
                    if (Opcode == OP_LOAD) begin
                        next_state_s = S_MEMREAD;
                    end else if (Opcode == OP_STORE) begin
                        next_state_s = S_MEMWRITE;
                    end else begin
                        next_state_s = S_FETCH;
                    end
                end
                S_MEMREAD: next_state_s = S_MEMWB;
                S_EXECR:   next_state_s = S_ALUWB;
                S_EXECI:   next_state_s = S_ALUWB;
                S_JAL:     next_state_s = S_ALUWB;
                default:   next_state_s = S_FETCH;
            endcase
        end
    end

    // Per-state datapath selects and raw enables.
    always_comb begin
        pcwrite_s  = 1'b0;
        memwrite_s = 1'b0;
        irwrite_s  = 1'b0;
        regwrite_s = 1'b0;
        retire_s   = 1'b0;
        AdrSrc     = 1'b0;
        ResultSrc  = 2'b00;
        ALUSrcA    = 2'b00;
        ALUSrcB    = 2'b00;
        ALUControl = 3'b000;
        case (state_r)
            S_FETCH: begin
                irwrite_s = 1'b1;
                pcwrite_s = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
            end
            S_DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
            end
            S_MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
            end
            S_MEMREAD: begin
                AdrSrc = 1'b1;
            end
            S_MEMWB: begin
                ResultSrc  = 2'b01;
                regwrite_s = 1'b1;
                retire_s   = 1'b1;
            end
            S_MEMWRITE: begin
                AdrSrc     = 1'b1;
                memwrite_s = 1'b1;
                retire_s   = 1'b1;
            end
            S_EXECR: begin
                ALUSrcA    = 2'b10;
                ALUControl = alu_decode(1'b1, Funct3, Funct7b5, Funct7b0);
            end
            S_EXECI: begin
                ALUSrcA    = 2'b10;
                ALUSrcB    = 2'b01;
                ALUControl = alu_decode(1'b0, Funct3, Funct7b5, Funct7b0);
            end
            S_ALUWB: begin
                regwrite_s = 1'b1;
                retire_s   = 1'b1;
            end
            S_BEQ: begin
                ALUSrcA    = 2'b10;
                ALUControl = 3'b001;
                pcwrite_s  = Zero;
                retire_s   = 1'b1;
            end
            S_JAL: begin
                ALUSrcA   = 2'b01;
                ALUSrcB   = 2'b10;
                pcwrite_s = 1'b1;
            end
            default: begin
                pcwrite_s = 1'b0;
            end
        endcase
    end

    // Immediate format depends only on the opcode, whatever the state.
    always_comb begin
        case (Opcode)
            OP_STORE: ImmSrc = 2'b01;
            OP_BEQ:   ImmSrc = 2'b10;
            OP_JAL:   ImmSrc = 2'b11;
            default:  ImmSrc = 2'b00;
        endcase
    end

    // The run flag clears asynchronously with rst_n, so all enables drop at once.
    assign PCWrite  = run_r & pcwrite_s;
    assign IRWrite  = run_r & irwrite_s;
    assign RegWrite = run_r & regwrite_s;
    assign MemWrite = run_r & memwrite_s;
    assign Retire   = run_r & retire_s;
    assign Illegal  = run_r & (state_r == S_DECODE) & illegal_s;
    assign StateDbg = state_r;

endmodule

// File: tb/tb_rv_multicycle_control.sv
// Testbench for rv_multicycle_control: random instruction streams are compared cycle by cycle
// against an instruction-level reference model that expands each instruction into its expected output rows.
module tb_rv_multicycle_control;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OPS [6] = '{OP_LW, OP_SW, OP_R, OP_I, OP_BEQ, OP_JAL};
    localparam logic [2:0] F3_OK [6] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd6, 3'd7};
    // funct3 -> add,sll,slt,-,xor,-,or,and
    localparam logic [2:0] F3_MAP [8] = '{3'd0, 3'd6, 3'd7, 3'd0, 3'd5, 3'd0, 3'd4, 3'd3};

    typedef struct packed {
        logic [3:0] st;
        logic       pcw, adr, memw, irw;
        logic [1:0] res, sa, sb, imm;
        logic       regw;
        logic [2:0] alu;
        logic       ill, ret;
    } row_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] Opcode;
    logic [2:0] Funct3;
    logic       Funct7b5, Funct7b0, Zero;
    logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, Illegal, Retire;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
    logic [2:0] ALUControl;
    logic [3:0] StateDbg;

    row_t exp_q [$];
    int   total = 0;
    int   bad = 0;

    rv_multicycle_control #(.STATE_WIDTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .Opcode(Opcode), .Funct3(Funct3),
        .Funct7b5(Funct7b5), .Funct7b0(Funct7b0), .Zero(Zero),
        .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc),
        .RegWrite(RegWrite), .ALUControl(ALUControl), .Illegal(Illegal),
        .Retire(Retire), .StateDbg(StateDbg)
    );

    always #5 clk = ~clk;

    function automatic row_t observe();
        return '{StateDbg, PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA,
                 ALUSrcB, ImmSrc, RegWrite, ALUControl, Illegal, Retire};
    endfunction

    function automatic logic [1:0] imm_ref(input logic [6:0] op);
        if (op == OP_SW) return 2'b01;
        if (op == OP_BEQ) return 2'b10;
        if (op == OP_JAL) return 2'b11;
        return 2'b00;
    endfunction

    function automatic logic [2:0] alu_ref(input logic is_r, input logic [2:0] f3, input logic b5, input logic b0);
        if (f3 == 3'd0 && is_r && b0) return 3'd2;
        if (f3 == 3'd0 && is_r && b5) return 3'd1;
        return F3_MAP[f3];
    endfunction

    function automatic logic legal_ref(input logic [6:0] op, input logic [2:0] f3, input logic b5, input logic b0);
        if (op == OP_LW || op == OP_SW) return f3 == 3'd2;
        if (op == OP_R) return f3 != 3'd3 && f3 != 3'd5 && !(b5 && b0);
        if (op == OP_I) return f3 != 3'd3 && f3 != 3'd5;
        if (op == OP_BEQ) return f3 == 3'd0;
        return op == OP_JAL;
    endfunction

    task automatic push(input logic [3:0] st, input logic pcw, input logic adr, input logic memw,
                        input logic irw, input logic [1:0] res, input logic [1:0] sa,
                        input logic [1:0] sb, input logic regw, input logic [2:0] alu,
                        input logic ill, input logic ret, input logic [1:0] imm);
        row_t r;
        r = '{st, pcw, adr, memw, irw, res, sa, sb, imm, regw, alu, ill, ret};
        exp_q.push_back(r);
    endtask

    // Expand one instruction into the rows the control unit must show, one per cycle.
    task automatic model_instr(input logic [6:0] op, input logic [2:0] f3, input logic b5,
                               input logic b0, input logic z);
        logic [1:0] im;
        logic       ok;
        im = imm_ref(op);
        ok = legal_ref(op, f3, b5, b0);
        push(4'd0, 1'b1, 1'b0, 1'b0, 1'b1, 2'd2, 2'd0, 2'd2, 1'b0, 3'd0, 1'b0, 1'b0, im);
        push(4'd1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd1, 2'd1, 1'b0, 3'd0, !ok, 1'b0, im);
        if (ok) begin
            if (op == OP_LW || op == OP_SW)
                push(4'd2, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd2, 2'd1, 1'b0, 3'd0, 1'b0, 1'b0, im);
            if (op == OP_LW) begin
                push(4'd3, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 1'b0, 3'd0, 1'b0, 1'b0, im);
                push(4'd4, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 2'd0, 2'd0, 1'b1, 3'd0, 1'b0, 1'b1, im);
            end
            if (op == OP_SW)
                push(4'd5, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 2'd0, 2'd0, 1'b0, 3'd0, 1'b0, 1'b1, im);
            if (op == OP_R)
                push(4'd6, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd2, 2'd0, 1'b0, alu_ref(1'b1, f3, b5, b0), 1'b0, 1'b0, im);
            if (op == OP_I)
                push(4'd7, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd2, 2'd1, 1'b0, alu_ref(1'b0, f3, b5, b0), 1'b0, 1'b0, im);
            if (op == OP_JAL)
                push(4'd10, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 2'd1, 2'd2, 1'b0, 3'd0, 1'b0, 1'b0, im);
            if (op == OP_R || op == OP_I || op == OP_JAL)
                push(4'd8, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 1'b1, 3'd0, 1'b0, 1'b1, im);
            if (op == OP_BEQ)
                push(4'd9, z, 1'b0, 1'b0, 1'b0, 2'd0, 2'd2, 2'd0, 1'b0, 3'd1, 1'b0, 1'b1, im);
        end
    endtask

    task automatic drive(input logic [6:0] op, input logic [2:0] f3, input logic b5,
                         input logic b0, input logic z);
        Opcode = op; Funct3 = f3; Funct7b5 = b5; Funct7b0 = b0; Zero = z;
        model_instr(op, f3, b5, b0, z);
    endtask

    task automatic gen_legal(output logic [6:0] op, output logic [2:0] f3, output logic b5,
                             output logic b0, output logic z);
        op = OPS[$urandom_range(0, 5)];
        f3 = F3_OK[$urandom_range(0, 5)];
        b5 = 1'($urandom_range(0, 1));
        b0 = 1'($urandom_range(0, 1));
        z  = 1'($urandom_range(0, 1));
        if (op == OP_R && b5 && b0) b0 = 1'b0;
        if (op == OP_LW || op == OP_SW) f3 = 3'd2;
        if (op == OP_BEQ) f3 = 3'd0;
    endtask

    task automatic gen_illegal(output logic [6:0] op, output logic [2:0] f3, output logic b5,
                               output logic b0, output logic z);
        for (int k = 0; k < 100; k++) begin
            op = ($urandom_range(0, 1) == 0) ? OPS[$urandom_range(0, 5)] : 7'($urandom);
            f3 = 3'($urandom);
            b5 = 1'($urandom_range(0, 1));
            b0 = 1'($urandom_range(0, 1));
            z  = 1'($urandom_range(0, 1));
            if (!legal_ref(op, f3, b5, b0)) break;
        end
        if (legal_ref(op, f3, b5, b0)) op = 7'd0;
    endtask

    task automatic test_reset();
        row_t e, o;
        e = '{4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 2'd0, 2'd2, 2'd0, 1'b0, 3'd0, 1'b0, 1'b0};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            o = observe();
            total++;
            if (o !== e) begin
                bad++;
                $display("FAIL reset cycle %0d: got %h expected %h", i, o, e);
            end
            @(posedge clk);
            #1;
            if (i == 2) rst_n = 1'b1;
        end
    endtask

    task automatic test_alu();
        logic [6:0] op; logic [2:0] f3; logic b5, b0, z;
        row_t e, o;
        for (int n = 0; n < 14; n++) begin
            gen_legal(op, f3, b5, b0, z);
            if (n == 0) begin op = OP_R; f3 = 3'd0; b5 = 1'b0; b0 = 1'b0; end
            if (n == 1) begin op = OP_R; f3 = 3'd0; b5 = 1'b0; b0 = 1'b1; end
            if (n == 2) begin op = OP_R; f3 = 3'd0; b5 = 1'b1; b0 = 1'b0; end
            if (n == 3) begin op = OP_I; f3 = 3'd0; b5 = 1'b1; b0 = 1'b1; end
            if (n > 3) op = ($urandom_range(0, 1) == 0) ? OP_R : OP_I;
            drive(op, f3, b5, b0, z);
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                @(negedge clk);
                o = observe();
                total++;
                if (o !== e) begin
                    bad++;
                    $display("FAIL alu op=%b f3=%b b5=%b b0=%b: got %h expected %h", op, f3, b5, b0, o, e);
                end
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic test_mem();
        logic [6:0] op;
        row_t e, o;
        for (int n = 0; n < 6; n++) begin
            op = (n % 2 == 0) ? OP_LW : OP_SW;
            drive(op, 3'd2, 1'($urandom_range(0, 1)), 1'b0, 1'($urandom_range(0, 1)));
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                @(negedge clk);
                o = observe();
                total++;
                if (o !== e) begin
                    bad++;
                    $display("FAIL mem op=%b: got %h expected %h", op, o, e);
                end
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic test_branch_jump();
        logic [6:0] op; logic z;
        row_t e, o;
        for (int n = 0; n < 6; n++) begin
            op = (n < 4) ? OP_BEQ : OP_JAL;
            z  = (n == 0) ? 1'b1 : (n == 1) ? 1'b0 : 1'($urandom_range(0, 1));
            drive(op, 3'd0, 1'b0, 1'b0, z);
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                @(negedge clk);
                o = observe();
                total++;
                if (o !== e) begin
                    bad++;
                    $display("FAIL branch op=%b zero=%b: got %h expected %h", op, z, o, e);
                end
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic test_illegal();
        logic [6:0] op; logic [2:0] f3; logic b5, b0, z;
        row_t e, o;
        for (int n = 0; n < 10; n++) begin
            gen_illegal(op, f3, b5, b0, z);
            if (n == 0) begin op = 7'd0; f3 = 3'd0; end
            if (n == 1) begin op = OP_R; f3 = 3'd5; b5 = 1'b0; b0 = 1'b0; end
            if (n == 2) begin op = OP_R; f3 = 3'd0; b5 = 1'b1; b0 = 1'b1; end
            drive(op, f3, b5, b0, z);
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                @(negedge clk);
                o = observe();
                total++;
                if (o !== e) begin
                    bad++;
                    $display("FAIL illegal op=%b f3=%b b5=%b b0=%b: got %h expected %h", op, f3, b5, b0, o, e);
                end
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [6:0] op; logic [2:0] f3; logic b5, b0, z;
        row_t e, o;
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 3) == 0) gen_illegal(op, f3, b5, b0, z);
            else gen_legal(op, f3, b5, b0, z);
            drive(op, f3, b5, b0, z);
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                @(negedge clk);
                o = observe();
                total++;
                if (o !== e) begin
                    bad++;
                    $display("FAIL b2b #%0d op=%b f3=%b: got %h expected %h", n, op, f3, o, e);
                end
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic test_reset_midinstr();
        logic [6:0] op; logic [2:0] f3; logic b5, b0, z;
        row_t e, o;
        drive(OP_SW, 3'd2, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            e = exp_q.pop_front();
            @(negedge clk);
            o = observe();
            total++;
            if (o !== e) begin
                bad++;
                $display("FAIL midreset sw row %0d: got %h expected %h", i, o, e);
            end
            if (i < 3) begin
                @(posedge clk);
                #1;
            end
        end
        #1 rst_n = 1'b0;
        #1;
        total++;
        if (MemWrite !== 1'b0 || StateDbg !== 4'd0 || Retire !== 1'b0) begin
            bad++;
            $display("FAIL midreset async: got memwrite=%b state=%0d retire=%b expected 0 0 0", MemWrite, StateDbg, Retire);
        end
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        e = '{4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 2'd0, 2'd2, 2'd1, 1'b0, 3'd0, 1'b0, 1'b0};
        @(negedge clk);
        o = observe();
        total++;
        if (o !== e) begin
            bad++;
            $display("FAIL midreset release: got %h expected %h", o, e);
        end
        @(posedge clk);
        #1;
        for (int n = 0; n < 3; n++) begin
            gen_legal(op, f3, b5, b0, z);
            drive(op, f3, b5, b0, z);
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                @(negedge clk);
                o = observe();
                total++;
                if (o !== e) begin
                    bad++;
                    $display("FAIL midreset restart op=%b: got %h expected %h", op, o, e);
                end
                @(posedge clk);
                #1;
            end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; Opcode = 7'd0; Funct3 = 3'd0;
        Funct7b5 = 1'b0; Funct7b0 = 1'b0; Zero = 1'b0;
        test_reset();
        test_alu();
        test_mem();
        test_branch_jump();
        test_illegal();
        test_back_to_back();
        test_reset_midinstr();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rv_multicycle_control.md
Name: rv_multicycle_control

Overview:
- Main control FSM of the multicycle RV32I datapath; sits directly upstream of the ALU.
- Decodes the latched instruction fields and sequences fetch/decode/execute/memory/writeback, one state per clock.
- Drives the ALU's 3-bit Control input plus all datapath mux selects and write enables.
- Supported subset: R-type (add/sub/mul/and/or/xor/sll/slt), I-type ALU, lw, sw, beq, jal.

Parameters:
- STATE_WIDTH, 4, width of the state register and the StateDbg port.

Ports:
- clk  input  1  single system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- Opcode  input  7  instr[6:0] from the instruction register.
- Funct3  input  3  instr[14:12].
- Funct7b5  input  1  instr[30].
- Funct7b0  input  1  instr[25] (M-extension mul select).
- Zero  input  1  ALU result == 0, sampled combinationally.
- PCWrite  output  1  PC register enable.
- AdrSrc  output  1  memory address select: 0 = PC, 1 = result.
- MemWrite  output  1  data memory write enable.
- IRWrite  output  1  instruction register and OldPC enable.
- ResultSrc  output  2  00 = ALUOut, 01 = Data, 10 = ALU result.
- ALUSrcA  output  2  00 = PC, 01 = OldPC, 10 = rs1 reg.
- ALUSrcB  output  2  00 = rs2 reg, 01 = imm, 10 = constant 4.
- ImmSrc  output  2  00 = I, 01 = S, 10 = B, 11 = J.
- RegWrite  output  1  register file write enable.
- ALUControl  output  3  000 add, 001 sub, 010 mul, 011 and, 100 or, 101 xor, 110 sll, 111 slt.
- Illegal  output  1  one-cycle pulse on an unsupported encoding.
- Retire  output  1  one-cycle pulse in the final state of each instruction.
- StateDbg  output  STATE_WIDTH  current state code.

Behaviour:
- Reset: state = FETCH (code 0); run flop = 0.
  - While run == 0, PCWrite/IRWrite/RegWrite/MemWrite/Illegal/Retire are forced to 0.
  - All other outputs take their FETCH-decoded values during reset.
  - run becomes 1 on the first clk edge after rst_n rises; the state holds FETCH until then. The first real fetch is therefore the second cycle after release.
- Reset asserted mid-instruction aborts it immediately and asynchronously; no partial write may occur after rst_n falls.
- States and codes:
  - FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECR 6, EXECI 7, ALUWB 8, BEQ 9, JAL 10.
- Transitions:
  - FETCH -> DECODE.
  - DECODE: lw/sw (0000011/0100011) -> MEMADR; R (0110011) -> EXECR; I-ALU (0010011) -> EXECI; beq (1100011) -> BEQ; jal (1101111) -> JAL; anything else -> FETCH with Illegal = 1.
  - MEMADR -> MEMREAD if lw, MEMWRITE if sw.
  - MEMREAD -> MEMWB; EXECR/EXECI/JAL -> ALUWB.
  - MEMWB, MEMWRITE, ALUWB, BEQ -> FETCH with Retire = 1.
- Moore outputs per state (unlisted enables = 0, unlisted selects = 00):
  - FETCH: AdrSrc 0, IRWrite 1, ALUSrcA 00, ALUSrcB 10, ALUControl add, ResultSrc 10, PCWrite 1.
  - DECODE: ALUSrcA 01, ALUSrcB 01, ALUControl add; ImmSrc from opcode in every state.
  - MEMADR: SrcA 10, SrcB 01, add.
  - MEMREAD: ResultSrc 00, AdrSrc 1.
  - MEMWB: ResultSrc 01, RegWrite 1.
  - MEMWRITE: ResultSrc 00, AdrSrc 1, MemWrite 1.
  - EXECR: SrcA 10, SrcB 00. EXECI: SrcA 10, SrcB 01.
  - ALUWB: ResultSrc 00, RegWrite 1.
  - JAL: SrcA 01, SrcB 10, add, ResultSrc 00, PCWrite 1.
  - BEQ: SrcA 10, SrcB 00, sub, ResultSrc 00; PCWrite = Zero (Mealy, same cycle).
- ALU decode, applied in EXECR/EXECI only:
  - R-type Funct3 000: Funct7b0 -> mul; else Funct7b5 -> sub; else add.
  - Funct3 001 sll, 010 slt, 100 xor, 110 or, 111 and.
  - Funct7b5 and Funct7b0 both set -> illegal.
  - I-type: same Funct3 map, but 000 is always add (no sub/mul).
- Illegal encodings are detected in DECODE and take DECODE -> FETCH:
  - R/I Funct3 011 or 101; beq with Funct3 != 000; lw with Funct3 != 010; sw with Funct3 != 010.
  - No write enable asserts for an illegal instruction.
- Cycle counts: R/I/jal 4, lw 5, sw 4, beq 3.

Test Plan:
- Reset release: rst_n low 3 cycles, then high -> all enables 0 through reset plus 1 cycle; IRWrite = 1 and PCWrite = 1 in the next cycle; StateDbg = 0.
- add then mul (Opcode 0110011, F3 000, F7b5 0 / F7b0 1) -> states 0,1,6,8; ALUControl 000 then 010 in EXECR; RegWrite = 1 only in ALUWB; Retire pulses every 4 cycles.
- lw (0000011, F3 010) -> states 0,1,2,3,4; AdrSrc 1 in MEMREAD; ResultSrc 01 and RegWrite 1 in MEMWB; 5 cycles. sw (0100011) -> MemWrite 1 only in state 5.
- beq with Zero = 1 vs Zero = 0 -> PCWrite 1 vs 0 in BEQ; ALUControl 001; 3 cycles each.
- Illegal: Opcode 0000000, and R-type F3 101 -> Illegal = 1 for one cycle in DECODE, next state FETCH, no RegWrite/MemWrite.
- rst_n pulsed low during MEMWRITE -> MemWrite drops asynchronously; state = 0; clean restart after release.
